// File: rtl/context_cache_mt_pkg.sv
// Shared types and helpers for the multi-threaded context cache.
package context_cache_mt_pkg;
  localparam int THREADS_DEF = 8;
  localparam int CTX_ID_W    = $clog2(THREADS_DEF);
  localparam int CTX_W       = 288;
  localparam int OPC_W       = 4;

  typedef enum logic [1:0] {ST_FREE, ST_WAITING, ST_RUNNING, ST_SLEEPING} thread_status_t;
  typedef enum logic [1:0] {NONE, PASS, COPY} exec_mode_t;
  typedef enum logic [1:0] {NO_FORK, FORK_ME_COPY, FORK_OTHER_PASS} fork_mode_t;

  typedef struct packed {
    logic [CTX_ID_W-1:0] id;
    logic                delete;
    logic                sleep;
    exec_mode_t          exec_mode;
    logic [CTX_ID_W-1:0] exec_id;
    fork_mode_t          fork_mode;
    logic                fork_sleep;
    logic [CTX_ID_W-1:0] fork_id;
  } ctx_ctrl_t;

  // Opcode field from op_src, everything below it from body.
  function automatic logic [CTX_W-1:0] pass_merge(input logic [CTX_W-1:0] op_src,
                                                  input logic [CTX_W-1:0] body);
    pass_merge = {op_src[CTX_W-1 -: OPC_W], body[CTX_W-OPC_W-1:0]};
  endfunction
endpackage

// File: rtl/context_cache_mt_alloc.sv
// Lowest and second-lowest FREE slot finder used by insert and fork allocation.
module context_cache_mt_alloc #(
  parameter int THREADS = 8,
  parameter int ID_W    = $clog2(THREADS)
) (
  input  logic [THREADS-1:0] free_vec,
  output logic [ID_W-1:0]    first_id,
  output logic               first_found,
  output logic [ID_W-1:0]    second_id,
  output logic               second_found
);
  always_comb begin
    first_id     = '0;
    first_found  = 1'b0;
    second_id    = '0;
    second_found = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (free_vec[i]) begin
        if (!first_found) begin
          first_found = 1'b1;
          first_id    = ID_W'(i);
        end else if (!second_found) begin
          second_found = 1'b1;
          second_id    = ID_W'(i);
        end
      end
    end
  end
endmodule

// File: rtl/context_cache_mt.sv
// Per-thread context store: insert, lend to execute, absorb returns/forks, sleep/wake,
// and a round-robin pick of the next WAITING thread.
module context_cache_mt
  import context_cache_mt_pkg::*;
#(
  parameter int THREADS   = THREADS_DEF,
  parameter int CONTEXT_W = CTX_W,
  parameter int OPCODE_W  = OPC_W,
  parameter int ID_W      = $clog2(THREADS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 user_insert,
  input  logic [CONTEXT_W-1:0] user_ctx,
  input  logic                 user_sleep,
  output logic [ID_W-1:0]      user_insert_id,
  output logic                 user_full,
  input  logic                 req_valid,
  input  logic [ID_W-1:0]      req_id,
  output logic [CONTEXT_W-1:0] req_ctx,
  output logic [ID_W-1:0]      req_ctx_id,
  input  logic                 ret_valid,
  input  ctx_ctrl_t            ret_ctrl,
  input  logic [CONTEXT_W-1:0] ret_ctx,
  input  logic                 wake_valid,
  input  logic [ID_W-1:0]      wake_id,
  output logic [ID_W:0]        waiting_count,
  output logic                 next_valid,
  output logic [ID_W-1:0]      next_id,
  output logic [3:0]           err
);
  thread_status_t       status_q [THREADS];
  thread_status_t       status_d [THREADS];
  logic [CONTEXT_W-1:0] ctx_q    [THREADS];
  logic [CONTEXT_W-1:0] ctx_d    [THREADS];

  logic [ID_W-1:0]      user_insert_id_q, user_insert_id_d;
  logic                 user_full_q, user_full_d;
  logic [CONTEXT_W-1:0] req_ctx_q, req_ctx_d;
  logic [ID_W-1:0]      req_ctx_id_q, req_ctx_id_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W:0]        waiting_count_q, waiting_count_d;
  logic                 next_valid_q, next_valid_d;
  logic [ID_W-1:0]      next_id_q, next_id_d;
  logic [3:0]           err_q, err_d;

  logic [THREADS-1:0]   free_vec;
  logic [ID_W-1:0]      first_id, second_id, ins_id;
  logic                 first_found, second_found, ins_found;
  logic                 ret_ok, fork_take;
  logic [CONTEXT_W-1:0] exec_pass_ctx, fork_pass_ctx;

  always_comb begin
    for (int i = 0; i < THREADS; i++) free_vec[i] = (status_q[i] == ST_FREE);
  end

  context_cache_mt_alloc #(.THREADS(THREADS), .ID_W(ID_W)) u_alloc (
    .free_vec    (free_vec),
    .first_id    (first_id),
    .first_found (first_found),
    .second_id   (second_id),
    .second_found(second_found)
  );

  // Package helper covers the default geometry; other widths slice directly.
  if (CONTEXT_W == CTX_W && OPCODE_W == OPC_W) begin : g_pkg_merge
    assign exec_pass_ctx = pass_merge(ctx_q[ret_ctrl.exec_id], ret_ctx);
    assign fork_pass_ctx = pass_merge(ctx_q[ret_ctrl.fork_id], ret_ctx);
  end else begin : g_slice_merge
    assign exec_pass_ctx = {ctx_q[ret_ctrl.exec_id][CONTEXT_W-1 -: OPCODE_W],
                            ret_ctx[CONTEXT_W-OPCODE_W-1:0]};
    assign fork_pass_ctx = {ctx_q[ret_ctrl.fork_id][CONTEXT_W-1 -: OPCODE_W],
                            ret_ctx[CONTEXT_W-OPCODE_W-1:0]};
  end

  // Every legality check looks at status_q, so the touched slots are always disjoint.
  always_comb begin
    status_d         = status_q;
    ctx_d            = ctx_q;
    user_insert_id_d = user_insert_id_q;
    req_ctx_d        = req_ctx_q;
    req_ctx_id_d     = req_ctx_id_q;
    rr_ptr_d         = rr_ptr_q;
    err_d            = '0;
    fork_take        = 1'b0;
    ins_id           = first_id;
    ins_found        = first_found;
    ret_ok           = ret_valid && (status_q[ret_ctrl.id] == ST_RUNNING);

    if (ret_ok) begin
      if (ret_ctrl.delete) begin
        status_d[ret_ctrl.id] = ST_FREE;
        ctx_d[ret_ctrl.id]    = '0;
      end else begin
        case (ret_ctrl.exec_mode)
          COPY:    ctx_d[ret_ctrl.id] = ctx_q[ret_ctrl.exec_id];
          PASS:    ctx_d[ret_ctrl.id] = exec_pass_ctx;
          default: ctx_d[ret_ctrl.id] = ret_ctx;
        endcase
        status_d[ret_ctrl.id] = ret_ctrl.sleep ? ST_SLEEPING : ST_WAITING;
        if (ret_ctrl.fork_mode != NO_FORK) begin
          if (first_found) begin
            fork_take          = 1'b1;
            status_d[first_id] = ret_ctrl.fork_sleep ? ST_SLEEPING : ST_WAITING;
            ctx_d[first_id]    = (ret_ctrl.fork_mode == FORK_OTHER_PASS) ? fork_pass_ctx : ret_ctx;
          end else begin
            err_d[3] = 1'b1;
          end
        end
      end
    end

    if (fork_take) begin
      ins_id    = second_id;
      ins_found = second_found;
    end
    if (user_insert) begin
      if (ins_found) begin
        status_d[ins_id] = user_sleep ? ST_SLEEPING : ST_WAITING;
        ctx_d[ins_id]    = user_ctx;
        user_insert_id_d = ins_id;
      end else begin
        err_d[2] = 1'b1;
      end
    end

    if (req_valid) begin
      if (status_q[req_id] == ST_WAITING) begin
        status_d[req_id] = ST_RUNNING;
        req_ctx_d        = ctx_q[req_id];
        req_ctx_id_d     = req_id;
        rr_ptr_d         = (req_id == ID_W'(THREADS-1)) ? '0 : req_id + 1'b1;
      end else begin
        err_d[0] = 1'b1;
      end
    end

    if (wake_valid) begin
      if (status_q[wake_id] == ST_SLEEPING) status_d[wake_id] = ST_WAITING;
      else                                  err_d[1] = 1'b1;
    end
  end

  // Summary outputs describe the post-edge state; rr_ptr is one past the last grant.
  always_comb begin
    waiting_count_d = '0;
    next_valid_d    = 1'b0;
    next_id_d       = '0;
    user_full_d     = 1'b1;
    for (int k = THREADS-1; k >= 0; k--) begin
      if (status_d[(int'(rr_ptr_d) + k) % THREADS] == ST_WAITING) begin
        next_valid_d = 1'b1;
        next_id_d    = ID_W'((int'(rr_ptr_d) + k) % THREADS);
      end
    end
    for (int i = 0; i < THREADS; i++) begin
      if (status_d[i] == ST_WAITING) waiting_count_d = waiting_count_d + 1'b1;
      if (status_d[i] == ST_FREE)    user_full_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < THREADS; i++) begin
        status_q[i] <= ST_FREE;
        ctx_q[i]    <= '0;
      end
      user_insert_id_q <= '0;
      user_full_q      <= 1'b0;
      req_ctx_q        <= '0;
      req_ctx_id_q     <= '0;
      rr_ptr_q         <= '0;
      waiting_count_q  <= '0;
      next_valid_q     <= 1'b0;
      next_id_q        <= '0;
      err_q            <= '0;
    end else begin
      status_q         <= status_d;
      ctx_q            <= ctx_d;
      user_insert_id_q <= user_insert_id_d;
      user_full_q      <= user_full_d;
      req_ctx_q        <= req_ctx_d;
      req_ctx_id_q     <= req_ctx_id_d;
      rr_ptr_q         <= rr_ptr_d;
      waiting_count_q  <= waiting_count_d;
      next_valid_q     <= next_valid_d;
      next_id_q        <= next_id_d;
      err_q            <= err_d;
    end
  end

  assign user_insert_id = user_insert_id_q;
  assign user_full      = user_full_q;
  assign req_ctx        = req_ctx_q;
  assign req_ctx_id     = req_ctx_id_q;
  assign waiting_count  = waiting_count_q;
  assign next_valid     = next_valid_q;
  assign next_id        = next_id_q;
  assign err            = err_q;
endmodule

// File: tb/tb_context_cache_mt.sv
// Directed bench for context_cache_mt with a slot-list reference model checked every cycle.
module tb_context_cache_mt;
  import context_cache_mt_pkg::*;

  localparam int T  = 8;
  localparam int CW = 288;
  localparam int IW = 3;
  localparam int F = 0, W = 1, R = 2, S = 3;
  localparam logic [CW-1:0] TOP = {4'hF, 284'h0};

  logic          clk;
  logic          rst;
  logic          user_insert, user_sleep, req_valid, ret_valid, wake_valid;
  logic [CW-1:0] user_ctx, ret_ctx, req_ctx;
  logic [IW-1:0] user_insert_id, req_id, req_ctx_id, wake_id, next_id;
  logic          user_full, next_valid;
  ctx_ctrl_t     ret_ctrl;
  logic [IW:0]   waiting_count;
  logic [3:0]    err;

  context_cache_mt dut (
    .clk(clk), .rst(rst),
    .user_insert(user_insert), .user_ctx(user_ctx), .user_sleep(user_sleep),
    .user_insert_id(user_insert_id), .user_full(user_full),
    .req_valid(req_valid), .req_id(req_id), .req_ctx(req_ctx), .req_ctx_id(req_ctx_id),
    .ret_valid(ret_valid), .ret_ctrl(ret_ctrl), .ret_ctx(ret_ctx),
    .wake_valid(wake_valid), .wake_id(wake_id),
    .waiting_count(waiting_count), .next_valid(next_valid), .next_id(next_id), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: slot states as ints, allocation from an ordered free list.
  int            m_st  [T];
  logic [CW-1:0] m_ctx [T];
  int            m_last;
  logic [IW-1:0] m_uid, m_rid, m_nid;
  logic [CW-1:0] m_rctx;
  logic          m_full, m_nv;
  int            m_cnt;
  logic [3:0]    m_err;

  task automatic model_reset();
    for (int i = 0; i < T; i++) begin
      m_st[i]  = F;
      m_ctx[i] = '0;
    end
    m_last = T - 1;
    m_uid = '0; m_rid = '0; m_nid = '0; m_rctx = '0;
    m_full = 1'b0; m_nv = 1'b0; m_cnt = 0; m_err = '0;
  endtask

  task automatic model_step();
    int            pst  [T];
    logic [CW-1:0] pctx [T];
    int            freeq[$];
    int            id, s;
    if (rst) begin
      model_reset();
      return;
    end
    pst = m_st;
    pctx = m_ctx;
    m_err = '0;
    for (int i = 0; i < T; i++) if (pst[i] == F) freeq.push_back(i);
    if (ret_valid && pst[ret_ctrl.id] == R) begin
      id = int'(ret_ctrl.id);
      if (ret_ctrl.delete) begin
        m_st[id] = F;
        m_ctx[id] = '0;
      end else begin
        if (ret_ctrl.exec_mode == COPY)      m_ctx[id] = pctx[ret_ctrl.exec_id];
        else if (ret_ctrl.exec_mode == PASS) m_ctx[id] = (pctx[ret_ctrl.exec_id] & TOP) | (ret_ctx & ~TOP);
        else                                 m_ctx[id] = ret_ctx;
        m_st[id] = ret_ctrl.sleep ? S : W;
        if (ret_ctrl.fork_mode != NO_FORK) begin
          if (freeq.size() > 0) begin
            s = freeq.pop_front();
            m_st[s] = ret_ctrl.fork_sleep ? S : W;
            m_ctx[s] = (ret_ctrl.fork_mode == FORK_OTHER_PASS) ?
                       ((pctx[ret_ctrl.fork_id] & TOP) | (ret_ctx & ~TOP)) : ret_ctx;
          end else m_err[3] = 1'b1;
        end
      end
    end
    if (user_insert) begin
      if (freeq.size() > 0) begin
        s = freeq.pop_front();
        m_st[s] = user_sleep ? S : W;
        m_ctx[s] = user_ctx;
        m_uid = IW'(s);
      end else m_err[2] = 1'b1;
    end
    if (req_valid) begin
      if (pst[req_id] == W) begin
        m_st[req_id] = R;
        m_rctx = pctx[req_id];
        m_rid = req_id;
        m_last = int'(req_id);
      end else m_err[0] = 1'b1;
    end
    if (wake_valid) begin
      if (pst[wake_id] == S) m_st[wake_id] = W;
      else m_err[1] = 1'b1;
    end
    m_cnt = 0;
    m_full = 1'b1;
    for (int i = 0; i < T; i++) begin
      if (m_st[i] == W) m_cnt++;
      if (m_st[i] == F) m_full = 1'b0;
    end
    m_nv = (m_cnt > 0);
    m_nid = '0;
    for (int k = T; k >= 1; k--) if (m_st[(m_last + k) % T] == W) m_nid = IW'((m_last + k) % T);
  endtask

  always @(negedge clk) begin
    chk("cyc user_insert_id", user_insert_id, m_uid);
    chk("cyc user_full", user_full, m_full);
    chk("cyc req_ctx", req_ctx, m_rctx);
    chk("cyc req_ctx_id", req_ctx_id, m_rid);
    chk("cyc waiting_count", waiting_count, m_cnt);
    chk("cyc next_valid", next_valid, m_nv);
    chk("cyc next_id", next_id, m_nid);
    chk("cyc err", err, m_err);
  end

  task automatic idle();
    user_insert = 1'b0; req_valid = 1'b0; ret_valid = 1'b0; wake_valid = 1'b0;
    user_sleep = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    idle();
  endtask

  task automatic set_ins(input logic [CW-1:0] c, input bit slp);
    user_insert = 1'b1; user_ctx = c; user_sleep = slp;
  endtask
  task automatic set_req(input int id);
    req_valid = 1'b1; req_id = IW'(id);
  endtask
  task automatic set_wake(input int id);
    wake_valid = 1'b1; wake_id = IW'(id);
  endtask
  task automatic set_ret(input int id, input bit del, input bit slp, input exec_mode_t em,
                         input int eid, input fork_mode_t fm, input bit fs, input int fid,
                         input logic [CW-1:0] c);
    ret_valid = 1'b1;
    ret_ctrl.id = CTX_ID_W'(id); ret_ctrl.delete = del; ret_ctrl.sleep = slp;
    ret_ctrl.exec_mode = em; ret_ctrl.exec_id = CTX_ID_W'(eid);
    ret_ctrl.fork_mode = fm; ret_ctrl.fork_sleep = fs; ret_ctrl.fork_id = CTX_ID_W'(fid);
    ret_ctx = c;
  endtask

  logic [CW-1:0] ca, cb, cc, cd, cf, cg, ch, cx, cr;

  initial begin
    ca = {4'hF, {71{4'hA}}};
    cb = {4'hE, {71{4'hB}}};
    cc = {4'hD, {71{4'hC}}};
    cd = {4'h8, {71{4'hD}}};
    cf = {4'h9, {71{4'h6}}};
    cg = {4'h1, {71{4'h7}}};
    ch = {4'h3, {71{4'h9}}};
    cx = {4'hC, {71{4'h5}}};
    cr = {4'h7, {71{4'h3}}};
    user_ctx = '0; ret_ctx = '0; ret_ctrl = '0; req_id = '0; wake_id = '0;
    idle();
    rst = 1'b1;
    model_reset();
    step(); step();
    chk("reset waiting_count", waiting_count, 0);
    chk("reset user_full", user_full, 0);
    chk("reset err", err, 0);
    chk("reset req_ctx", req_ctx, 0);
    rst = 1'b0;

    set_ins(ca, 0); step();
    set_ins(cb, 0); step();
    set_ins(cc, 0); step();
    chk("insert id", user_insert_id, 2);
    chk("insert count", waiting_count, 3);
    chk("insert next_id", next_id, 0);
    chk("insert full", user_full, 0);

    set_req(1); step();
    chk("req ctx B", req_ctx, cb);
    chk("req ctx_id", req_ctx_id, 1);
    chk("req count", waiting_count, 2);
    set_req(1); step();
    chk("req_bad pulse", err, 4'b0001);
    chk("req_bad count", waiting_count, 2);
    step();
    chk("err clears", err, 4'b0000);

    set_req(0); step();
    set_ret(0, 0, 0, PASS, 1, NO_FORK, 0, 0, ca); step();
    chk("pass count", waiting_count, 2);
    set_req(0); step();
    chk("pass merged ctx", req_ctx, {4'hE, {71{4'hA}}});

    set_req(2); step();
    chk("all running count", waiting_count, 0);
    chk("all running next_valid", next_valid, 0);
    set_ret(2, 0, 1, NONE, 0, NO_FORK, 0, 0, cd); step();
    chk("sleep count", waiting_count, 0);
    set_wake(2); step();
    chk("wake count", waiting_count, 1);
    chk("wake next_id", next_id, 2);
    set_wake(2); step();
    chk("wake_bad pulse", err, 4'b0010);

    for (int k = 0; k < 4; k++) begin
      set_ins(CW'(32'h1000 + k), 0); step();
    end
    chk("one free left", user_full, 0);
    set_ret(0, 0, 0, NONE, 0, FORK_ME_COPY, 0, 0, cf);
    set_ins(cg, 0); step();
    chk("fork+insert err", err, 4'b0100);
    chk("fork+insert full", user_full, 1);
    chk("fork+insert id held", user_insert_id, 6);
    chk("fork+insert count", waiting_count, 7);
    set_ret(1, 0, 0, NONE, 0, FORK_ME_COPY, 0, 0, ch); step();
    chk("fork_drop err", err, 4'b1000);
    chk("fork_drop count", waiting_count, 8);
    set_req(1); step();
    chk("fork_drop parent ctx", req_ctx, ch);
    set_req(7); step();
    chk("fork child ctx", req_ctx, cf);

    #3 rst = 1'b1;
    model_reset();
    #1;
    chk("async rst req_ctx", req_ctx, 0);
    chk("async rst req_ctx_id", req_ctx_id, 0);
    chk("async rst count", waiting_count, 0);
    chk("async rst full", user_full, 0);
    chk("async rst insert_id", user_insert_id, 0);
    step();
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      set_ins({4'(k + 1), {71{4'(k)}}}, 0); step();
    end
    set_req(0); step();
    set_req(2); step();
    set_req(4); step();
    set_req(3); step();
    set_ret(3, 0, 0, NONE, 0, NO_FORK, 0, 0, cx); step();
    chk("rr next after 3", next_id, 5);
    set_req(5); step();
    chk("rr wrap to 1", next_id, 1);
    set_ret(5, 0, 0, COPY, 3, FORK_OTHER_PASS, 1, 1, cr); step();
    set_wake(6); set_req(6); step();
    chk("req on waking slot", err, 4'b0001);
    set_req(6); step();
    chk("fork pass child", req_ctx, {4'h2, {71{4'h3}}});
    set_req(5); step();
    chk("copy parent", req_ctx, cx);
    set_ret(6, 1, 0, NONE, 0, FORK_ME_COPY, 0, 0, cr);
    set_wake(6); step();
    chk("wake deleted slot", err, 4'b0010);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
